// File: rtl/board_mem_arbiter.sv
// Board RAM arbiter: video reads take priority and game accesses fill the idle slots; reads return on their owner's port.
// Latency: mem_* 1 edge after sampling, rdata/rvalid 3 edges after sampling. Backpressure: game holds gm_req until gm_gnt; video has none.
module board_mem_arbiter #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 3,
    parameter int DEPTH         = 200,
    parameter int WR_BLANK_ONLY = 1,
    parameter int STARVE_MAX    = 16
) (
    input  logic              pixclk,
    input  logic              rst_n,
    input  logic              vde,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    input  logic              gm_req,
    input  logic              gm_we,
    input  logic [ADDR_W-1:0] gm_addr,
    input  logic [DATA_W-1:0] gm_wdata,
    output logic              gm_gnt,
    output logic [DATA_W-1:0] gm_rdata,
    output logic              gm_rvalid,
    output logic              gm_oob,
    output logic              gm_starve,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W:0] DEPTH_C  = DEPTH[ADDR_W:0];
    localparam logic [CW-1:0]   STARVE_C = CW'(STARVE_MAX);

    typedef enum logic {G_IDLE, G_ACK} gstate_t;

    gstate_t           gstate;
    logic [CW-1:0]     pend_cnt;
    logic              t1_vld, t1_gm, t1_oob;
    logic              t2_vld, t2_gm, t2_oob;

    logic              gm_blocked;
    logic              gm_take;
    logic              issue;
    logic              issue_rd;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_in_range;
    logic [DATA_W-1:0] ret_dat;

    // Writes during active video would tear the displayed frame; reads are harmless.
    assign gm_blocked   = gm_we && (WR_BLANK_ONLY != 0) && vde;
    assign gm_take      = !vid_req && gm_req && (gstate == G_IDLE) && !gm_blocked;
    assign issue        = vid_req || gm_take;
    assign issue_rd     = vid_req || (gm_take && !gm_we);
    assign sel_addr     = vid_req ? vid_addr : gm_addr;
    assign sel_in_range = ({1'b0, sel_addr} < DEPTH_C);
    assign ret_dat      = t2_oob ? '0 : mem_rdata;
    assign gm_starve    = (pend_cnt == STARVE_C);

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            gstate     <= G_IDLE;
            pend_cnt   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            gm_gnt     <= 1'b0;
            gm_oob     <= 1'b0;
            t1_vld     <= 1'b0;
            t1_gm      <= 1'b0;
            t1_oob     <= 1'b0;
            t2_vld     <= 1'b0;
            t2_gm      <= 1'b0;
            t2_oob     <= 1'b0;
            vid_rvalid <= 1'b0;
            vid_rdata  <= '0;
            gm_rvalid  <= 1'b0;
            gm_rdata   <= '0;
        end else begin
            mem_en    <= issue && sel_in_range;
            mem_we    <= gm_take && gm_we && sel_in_range;
            mem_addr  <= issue ? sel_addr : '0;
            mem_wdata <= gm_take ? gm_wdata : '0;
            gm_gnt    <= gm_take;
            gm_oob    <= gm_take && !sel_in_range;

            case (gstate)
                G_IDLE:  if (gm_take) gstate <= G_ACK;
                default: gstate <= G_IDLE;
            endcase

            // Tag stage 1 lines up with mem_*, stage 2 with mem_rdata.
            t1_vld <= issue_rd;
            t1_gm  <= !vid_req;
            t1_oob <= !sel_in_range;
            t2_vld <= t1_vld;
            t2_gm  <= t1_gm;
            t2_oob <= t1_oob;

            vid_rvalid <= t2_vld && !t2_gm;
            gm_rvalid  <= t2_vld && t2_gm;
            if (t2_vld && !t2_gm) vid_rdata <= ret_dat;
            if (t2_vld && t2_gm)  gm_rdata  <= ret_dat;

            if (!gm_req || gm_take)
                pend_cnt <= '0;
            else if (pend_cnt != STARVE_C)
                pend_cnt <= pend_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter with a behavioural 1-cycle-read RAM.
module tb_board_mem_arbiter;

    logic       pixclk = 1'b0;
    logic       rst_n;
    logic       vde;
    logic       vid_req;
    logic [7:0] vid_addr;
    logic [2:0] vid_rdata;
    logic       vid_rvalid;
    logic       gm_req;
    logic       gm_we;
    logic [7:0] gm_addr;
    logic [2:0] gm_wdata;
    logic       gm_gnt;
    logic [2:0] gm_rdata;
    logic       gm_rvalid;
    logic       gm_oob;
    logic       gm_starve;
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [2:0] mem_wdata;
    logic [2:0] mem_rdata;

    logic [2:0] ram [256];
    int         total = 0;
    int         bad   = 0;
    int         gnt_seen;

    board_mem_arbiter dut (
        .pixclk     (pixclk),
        .rst_n      (rst_n),
        .vde        (vde),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_rdata  (vid_rdata),
        .vid_rvalid (vid_rvalid),
        .gm_req     (gm_req),
        .gm_we      (gm_we),
        .gm_addr    (gm_addr),
        .gm_wdata   (gm_wdata),
        .gm_gnt     (gm_gnt),
        .gm_rdata   (gm_rdata),
        .gm_rvalid  (gm_rvalid),
        .gm_oob     (gm_oob),
        .gm_starve  (gm_starve),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 pixclk = ~pixclk;

    always @(posedge pixclk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge pixclk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 3'(i);
        ram[5]    = 3'd6;
        ram[7]    = 3'd2;
        ram[12]   = 3'd1;
        mem_rdata = 3'd0;
        rst_n = 1'b0; vde = 1'b0;
        vid_req = 1'b0; vid_addr = '0;
        gm_req = 1'b0; gm_we = 1'b0; gm_addr = '0; gm_wdata = '0;
        #23;
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_gm_gnt", 32'(gm_gnt), 0);
        chk("rst_vid_rvalid", 32'(vid_rvalid), 0);
        chk("rst_starve", 32'(gm_starve), 0);
        rst_n = 1'b1;
        step();

        // Video read of address 5
        vid_req = 1'b1; vid_addr = 8'd5;
        step();
        chk("vid_mem_en", 32'(mem_en), 1);
        chk("vid_mem_addr", 32'(mem_addr), 5);
        chk("vid_mem_we", 32'(mem_we), 0);
        vid_req = 1'b0;
        step();
        chk("vid_rvalid_e1", 32'(vid_rvalid), 0);
        step();
        chk("vid_rvalid_e2", 32'(vid_rvalid), 1);
        chk("vid_rdata_e2", 32'(vid_rdata), 6);
        step();
        chk("vid_rvalid_e3", 32'(vid_rvalid), 0);

        // Collision: video at 5 and game read of 7 together
        vid_req = 1'b1; vid_addr = 8'd5;
        gm_req = 1'b1; gm_we = 1'b0; gm_addr = 8'd7;
        step();
        chk("col_gnt_e0", 32'(gm_gnt), 0);
        chk("col_mem_addr_e0", 32'(mem_addr), 5);
        vid_req = 1'b0;
        step();
        chk("col_gnt_e1", 32'(gm_gnt), 1);
        chk("col_mem_addr_e1", 32'(mem_addr), 7);
        gm_req = 1'b0;
        step();
        chk("col_gnt_e2", 32'(gm_gnt), 0);
        chk("col_vid_rvalid", 32'(vid_rvalid), 1);
        chk("col_gm_rvalid_e2", 32'(gm_rvalid), 0);
        step();
        chk("col_gm_rvalid_e3", 32'(gm_rvalid), 1);
        chk("col_gm_rdata", 32'(gm_rdata), 2);
        step();
        chk("col_gm_rvalid_e4", 32'(gm_rvalid), 0);

        // Game read is not blocked by active video
        vde = 1'b1; gm_req = 1'b1; gm_we = 1'b0; gm_addr = 8'd3;
        step();
        chk("rd_in_vde_gnt", 32'(gm_gnt), 1);
        gm_req = 1'b0;
        step(); step(); step();

        // Write blocked during active video, starvation after 16 pending edges
        gm_req = 1'b1; gm_we = 1'b1; gm_addr = 8'd12; gm_wdata = 3'd4;
        gnt_seen = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (gm_gnt) gnt_seen++;
            if (k == 15) chk("starve_k15", 32'(gm_starve), 0);
            if (k == 16) chk("starve_k16", 32'(gm_starve), 1);
        end
        chk("blk_no_gnt", 32'(gnt_seen), 0);
        chk("blk_starve_k20", 32'(gm_starve), 1);
        vde = 1'b0;
        step();
        chk("wr_gnt", 32'(gm_gnt), 1);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_en", 32'(mem_en), 1);
        chk("wr_mem_wdata", 32'(mem_wdata), 4);
        chk("wr_starve_clr", 32'(gm_starve), 0);
        gm_req = 1'b0; gm_we = 1'b0;
        step();
        chk("wr_ram12", 32'(ram[12]), 4);
        chk("wr_gnt_drop", 32'(gm_gnt), 0);
        step();

        // Out-of-range game read
        gm_req = 1'b1; gm_we = 1'b0; gm_addr = 8'd200;
        step();
        chk("oob_gnt", 32'(gm_gnt), 1);
        chk("oob_flag", 32'(gm_oob), 1);
        chk("oob_mem_en", 32'(mem_en), 0);
        gm_req = 1'b0;
        step();
        chk("oob_flag_drop", 32'(gm_oob), 0);
        step();
        chk("oob_rvalid", 32'(gm_rvalid), 1);
        chk("oob_rdata", 32'(gm_rdata), 0);

        // Reset in the middle of back-to-back video reads
        vid_req = 1'b1; vid_addr = 8'd5;
        step();
        vid_addr = 8'd7;
        step();
        #2;
        rst_n = 1'b0; vid_req = 1'b0;
        #1;
        chk("mrst_mem_en", 32'(mem_en), 0);
        chk("mrst_mem_addr", 32'(mem_addr), 0);
        chk("mrst_vid_rvalid", 32'(vid_rvalid), 0);
        chk("mrst_vid_rdata", 32'(vid_rdata), 0);
        #2;
        rst_n = 1'b1;
        gnt_seen = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (vid_rvalid) gnt_seen++;
        end
        chk("mrst_no_rvalid", 32'(gnt_seen), 0);
        vid_req = 1'b1; vid_addr = 8'd7;
        step();
        vid_req = 1'b0;
        step();
        chk("post_rst_rvalid_e1", 32'(vid_rvalid), 0);
        step();
        chk("post_rst_rvalid_e2", 32'(vid_rvalid), 1);
        chk("post_rst_rdata", 32'(vid_rdata), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
